// File: rtl/rv64_lsu_pkg.sv
// rv64_lsu_pkg
//  Shared definitions for the RV64I load/store unit:
//   - funct3 encodings for loads (LB..LWU) and stores (SB..SD)
//   - access size codes (funct3[1:0])
//   - load/store FSM state encoding
//   - byte-lane write mask helper
package rv64_lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_WAIT   = 2'b10,
        ST_RESP   = 2'b11
    } state_e;

    // Byte-lane enables for an access of the given size at byte offset off.
    function automatic logic [7:0] lane_mask(input size_e size, input logic [2:0] off);
        logic [7:0] m;
        case (size)
            SZ_B:    m = 8'h01 << off;
            SZ_H:    m = 8'h03 << off;
            SZ_W:    m = 8'h0F << off;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align
//  Combinational alignment helper for the load/store unit.
//  Ports:
//   is_store_i   1   1 = store, 0 = load
//   funct3_i     3   RV64I load/store funct3
//   off_i        3   byte offset within the 64-bit word
//   wdata_i      64  store data, LSB-aligned
//   rdata_i      64  raw memory read data
//   we_mask_o    8   byte-lane write enables
//   wdata_o      64  store data shifted onto its lanes
//   load_data_o  64  shifted and sign/zero-extended load result
//   fault_o      1   misaligned access or illegal funct3
module lsu_align
    import rv64_lsu_pkg::*;
(
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [2:0]  off_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] rdata_i,
    output logic [7:0]  we_mask_o,
    output logic [63:0] wdata_o,
    output logic [63:0] load_data_o,
    output logic        fault_o
);

    size_e       size;
    logic [63:0] rshift;
    logic        misaligned;
    logic        illegal;

    assign size      = size_e'(funct3_i[1:0]);
    assign we_mask_o = lane_mask(size, off_i);
    assign wdata_o   = wdata_i << {off_i, 3'b000};
    assign rshift    = rdata_i >> {off_i, 3'b000};

    always_comb begin
        misaligned = 1'b0;
        case (size)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = off_i[0];
            SZ_W:    misaligned = |off_i[1:0];
            default: misaligned = |off_i;
        endcase
    end

    // Only funct3 = 111 is illegal for loads; stores have no unsigned forms.
    always_comb begin
        illegal = 1'b0;
        if (is_store_i)
            illegal = !(funct3_i inside {F3_SB, F3_SH, F3_SW, F3_SD});
        else
            illegal = !(funct3_i inside {F3_LB, F3_LH, F3_LW, F3_LD, F3_LBU, F3_LHU, F3_LWU});
    end

    assign fault_o = misaligned | illegal;

    always_comb begin
        load_data_o = rshift;
        case (funct3_i)
            F3_LB:   load_data_o = {{56{rshift[7]}},  rshift[7:0]};
            F3_LH:   load_data_o = {{48{rshift[15]}}, rshift[15:0]};
            F3_LW:   load_data_o = {{32{rshift[31]}}, rshift[31:0]};
            F3_LBU:  load_data_o = {56'd0, rshift[7:0]};
            F3_LHU:  load_data_o = {48'd0, rshift[15:0]};
            F3_LWU:  load_data_o = {32'd0, rshift[31:0]};
            default: load_data_o = rshift;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
//  Memory-access stage: executes RV64I loads/stores on a 64-bit data memory,
//  one outstanding request at a time, and returns write-back data for rd.
//  Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_is_store, req_funct3   operation select
//   req_addr, req_wdata        byte address, LSB-aligned store data
//   req_rd                     destination register for loads
//   resp_valid                 one-cycle response pulse
//   resp_data/resp_rd/fault    response payload, held until next response
//   mem_addr/re/we/wdata       memory request (word address, byte lanes)
//   mem_rdata                  memory read data
module load_store_unit
    import rv64_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int XLEN        = 64,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [XLEN-1:0]       req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    input  logic [4:0]            req_rd,
    output logic                  resp_valid,
    output logic [XLEN-1:0]       resp_data,
    output logic [4:0]            resp_rd,
    output logic                  resp_fault,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    output logic [7:0]            mem_we,
    output logic [63:0]           mem_wdata,
    input  logic [63:0]           mem_rdata
);

    localparam int CNT_W = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);

    state_e                state_q, state_d;
    logic                  is_store_q, is_store_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [2:0]            off_q, off_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [4:0]            rd_q, rd_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [XLEN-1:0]       resp_data_q, resp_data_d;
    logic [4:0]            resp_rd_q, resp_rd_d;
    logic                  resp_fault_q, resp_fault_d;

    logic                  idle;
    logic                  al_is_store;
    logic [2:0]            al_funct3;
    logic [2:0]            al_off;
    logic [7:0]            al_mask;
    logic [63:0]           al_wdata;
    logic [63:0]           al_load;
    logic                  al_fault;
    logic                  unused_addr_hi;

    // Address bits above the memory window wrap around.
    assign unused_addr_hi = ^req_addr[XLEN-1:ADDR_WIDTH+3];

    assign idle = (state_q == ST_IDLE);

    // In IDLE the aligner sees the live request so a fault can be decided at
    // accept; afterwards it works from the latched copy.
    assign al_is_store = idle ? req_is_store  : is_store_q;
    assign al_funct3   = idle ? req_funct3    : funct3_q;
    assign al_off      = idle ? req_addr[2:0] : off_q;

    lsu_align u_align (
        .is_store_i  (al_is_store),
        .funct3_i    (al_funct3),
        .off_i       (al_off),
        .wdata_i     (wdata_q),
        .rdata_i     (mem_rdata),
        .we_mask_o   (al_mask),
        .wdata_o     (al_wdata),
        .load_data_o (al_load),
        .fault_o     (al_fault)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= '0;
            off_q        <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
            resp_data_q  <= '0;
            resp_rd_q    <= '0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
            resp_data_q  <= resp_data_d;
            resp_rd_q    <= resp_rd_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        cnt_d        = cnt_q;
        resp_data_d  = resp_data_q;
        resp_rd_d    = resp_rd_q;
        resp_fault_d = resp_fault_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    is_store_d = req_is_store;
                    funct3_d   = req_funct3;
                    off_d      = req_addr[2:0];
                    waddr_d    = req_addr[ADDR_WIDTH+2:3];
                    wdata_d    = req_wdata;
                    rd_d       = req_rd;
                    if (al_fault) begin
                        state_d      = ST_RESP;
                        resp_data_d  = '0;
                        resp_rd_d    = req_rd;
                        resp_fault_d = 1'b1;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (is_store_q) begin
                    state_d      = ST_RESP;
                    resp_data_d  = '0;
                    resp_rd_d    = rd_q;
                    resp_fault_d = 1'b0;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(MEM_LATENCY);
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d      = ST_RESP;
                    resp_data_d  = al_load;
                    resp_rd_d    = rd_q;
                    resp_fault_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready  = idle;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_data  = resp_data_q;
    assign resp_rd    = resp_rd_q;
    assign resp_fault = resp_fault_q;
    assign mem_addr   = waddr_q;
    assign mem_re     = (state_q == ST_ACCESS) && !is_store_q;
    assign mem_we     = ((state_q == ST_ACCESS) && is_store_q) ? al_mask  : 8'h00;
    assign mem_wdata  = ((state_q == ST_ACCESS) && is_store_q) ? al_wdata : 64'd0;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT a: MEM_LATENCY = 1
    logic        a_rst_n, a_req_valid, a_req_ready, a_req_is_store;
    logic [2:0]  a_req_funct3;
    logic [63:0] a_req_addr, a_req_wdata;
    logic [4:0]  a_req_rd;
    logic        a_resp_valid, a_resp_fault;
    logic [63:0] a_resp_data;
    logic [4:0]  a_resp_rd;
    logic [9:0]  a_mem_addr;
    logic        a_mem_re;
    logic [7:0]  a_mem_we;
    logic [63:0] a_mem_wdata, a_mem_rdata;

    // DUT b: MEM_LATENCY = 3
    logic        b_rst_n, b_req_valid, b_req_ready, b_req_is_store;
    logic [2:0]  b_req_funct3;
    logic [63:0] b_req_addr, b_req_wdata;
    logic [4:0]  b_req_rd;
    logic        b_resp_valid, b_resp_fault;
    logic [63:0] b_resp_data;
    logic [4:0]  b_resp_rd;
    logic [9:0]  b_mem_addr;
    logic        b_mem_re;
    logic [7:0]  b_mem_we;
    logic [63:0] b_mem_wdata, b_mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    load_store_unit #(.ADDR_WIDTH(10), .XLEN(64), .MEM_LATENCY(1)) u_a (
        .clk(clk), .rst_n(a_rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_is_store(a_req_is_store), .req_funct3(a_req_funct3), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .req_rd(a_req_rd), .resp_valid(a_resp_valid),
        .resp_data(a_resp_data), .resp_rd(a_resp_rd), .resp_fault(a_resp_fault),
        .mem_addr(a_mem_addr), .mem_re(a_mem_re), .mem_we(a_mem_we),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    load_store_unit #(.ADDR_WIDTH(10), .XLEN(64), .MEM_LATENCY(3)) u_b (
        .clk(clk), .rst_n(b_rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_is_store(b_req_is_store), .req_funct3(b_req_funct3), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .req_rd(b_req_rd), .resp_valid(b_resp_valid),
        .resp_data(b_resp_data), .resp_rd(b_resp_rd), .resp_fault(b_resp_fault),
        .mem_addr(b_mem_addr), .mem_re(b_mem_re), .mem_we(b_mem_we),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // Present a request on DUT a, return 1 ns after the accepting edge.
    task automatic issue_a(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] wd, input logic [4:0] rd);
        @(negedge clk);
        a_req_valid = 1'b1; a_req_is_store = st; a_req_funct3 = f3;
        a_req_addr = addr; a_req_wdata = wd; a_req_rd = rd;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
    endtask

    task automatic issue_b(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] wd, input logic [4:0] rd);
        @(negedge clk);
        b_req_valid = 1'b1; b_req_is_store = st; b_req_funct3 = f3;
        b_req_addr = addr; b_req_wdata = wd; b_req_rd = rd;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
    endtask

    // Number of edges after accept until resp_valid is seen; -1 on timeout.
    task automatic wait_resp_a(output int lat);
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (a_resp_valid) begin lat = k; break; end
        end
    endtask

    task automatic wait_resp_b(output int lat);
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (b_resp_valid) begin lat = k; break; end
        end
    endtask

    task automatic test_reset();
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (a_req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b exp 1", a_req_ready); end
        n_vec++; if (a_resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b exp 0", a_resp_valid); end
        n_vec++; if (a_resp_data !== 64'd0) begin n_err++; $display("FAIL rst_resp_data: got %h exp 0", a_resp_data); end
        n_vec++; if (a_resp_rd !== 5'd0) begin n_err++; $display("FAIL rst_resp_rd: got %0d exp 0", a_resp_rd); end
        n_vec++; if (a_resp_fault !== 1'b0) begin n_err++; $display("FAIL rst_resp_fault: got %b exp 0", a_resp_fault); end
        n_vec++; if (a_mem_re !== 1'b0 || a_mem_we !== 8'h00) begin n_err++; $display("FAIL rst_mem_strobes: got re=%b we=%h exp 0/00", a_mem_re, a_mem_we); end
        n_vec++; if (a_mem_addr !== 10'd0) begin n_err++; $display("FAIL rst_mem_addr: got %h exp 0", a_mem_addr); end
        n_vec++; if (b_req_ready !== 1'b1) begin n_err++; $display("FAIL rst_b_ready: got %b exp 1", b_req_ready); end
    endtask

    task automatic test_store_sd();
        int lat;
        issue_a(1'b1, 3'b011, 64'h10, 64'h1122334455667788, 5'd5);
        n_vec++; if (a_mem_addr !== 10'd2) begin n_err++; $display("FAIL sd_addr: got %h exp 2", a_mem_addr); end
        n_vec++; if (a_mem_we !== 8'hFF) begin n_err++; $display("FAIL sd_we: got %h exp ff", a_mem_we); end
        n_vec++; if (a_mem_wdata !== 64'h1122334455667788) begin n_err++; $display("FAIL sd_wdata: got %h exp 1122334455667788", a_mem_wdata); end
        n_vec++; if (a_mem_re !== 1'b0 || a_req_ready !== 1'b0) begin n_err++; $display("FAIL sd_re_ready: got re=%b rdy=%b exp 0/0", a_mem_re, a_req_ready); end
        wait_resp_a(lat);
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL sd_latency: got %0d exp 2", lat); end
        n_vec++; if (a_resp_fault !== 1'b0 || a_resp_data !== 64'd0) begin n_err++; $display("FAIL sd_resp: got fault=%b data=%h exp 0/0", a_resp_fault, a_resp_data); end
        n_vec++; if (a_resp_rd !== 5'd5) begin n_err++; $display("FAIL sd_resp_rd: got %0d exp 5", a_resp_rd); end
        @(negedge clk);
        n_vec++; if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1 || a_mem_we !== 8'h00) begin
            n_err++; $display("FAIL sd_after: got valid=%b rdy=%b we=%h exp 0/1/00", a_resp_valid, a_req_ready, a_mem_we); end
    endtask

    task automatic test_store_sb();
        int lat;
        issue_a(1'b1, 3'b000, 64'h13, 64'hAB, 5'd0);
        n_vec++; if (a_mem_addr !== 10'd2) begin n_err++; $display("FAIL sb_addr: got %h exp 2", a_mem_addr); end
        n_vec++; if (a_mem_we !== 8'h08) begin n_err++; $display("FAIL sb_we: got %h exp 08", a_mem_we); end
        n_vec++; if (a_mem_wdata !== 64'h00000000AB000000) begin n_err++; $display("FAIL sb_wdata: got %h exp 00000000ab000000", a_mem_wdata); end
        wait_resp_a(lat);
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL sb_latency: got %0d exp 2", lat); end
        // SH at offset 6 lands on lanes 6-7
        issue_a(1'b1, 3'b001, 64'h1E, 64'hBEEF, 5'd0);
        n_vec++; if (a_mem_we !== 8'hC0 || a_mem_wdata !== 64'hBEEF000000000000 || a_mem_addr !== 10'd3) begin
            n_err++; $display("FAIL sh_lanes: got we=%h wd=%h addr=%h exp c0/beef000000000000/3", a_mem_we, a_mem_wdata, a_mem_addr); end
        wait_resp_a(lat);
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL sh_latency: got %0d exp 2", lat); end
    endtask

    task automatic test_load_byte();
        int lat;
        a_mem_rdata = 64'h0000000080000000;
        issue_a(1'b0, 3'b000, 64'h13, 64'd0, 5'd7);
        n_vec++; if (a_mem_re !== 1'b1 || a_mem_we !== 8'h00 || a_mem_addr !== 10'd2) begin
            n_err++; $display("FAIL lb_access: got re=%b we=%h addr=%h exp 1/00/2", a_mem_re, a_mem_we, a_mem_addr); end
        wait_resp_a(lat);
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL lb_latency: got %0d exp 3", lat); end
        n_vec++; if (a_resp_data !== 64'hFFFFFFFFFFFFFF80) begin n_err++; $display("FAIL lb_data: got %h exp ffffffffffffff80", a_resp_data); end
        n_vec++; if (a_resp_rd !== 5'd7 || a_resp_fault !== 1'b0) begin n_err++; $display("FAIL lb_rd_fault: got rd=%0d fault=%b exp 7/0", a_resp_rd, a_resp_fault); end
        issue_a(1'b0, 3'b100, 64'h13, 64'd0, 5'd8);
        wait_resp_a(lat);
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL lbu_latency: got %0d exp 3", lat); end
        n_vec++; if (a_resp_data !== 64'h80) begin n_err++; $display("FAIL lbu_data: got %h exp 80", a_resp_data); end
    endtask

    task automatic test_load_half_word_double();
        int lat;
        a_mem_rdata = 64'hDEADBEEF00000000;
        issue_a(1'b0, 3'b010, 64'h14, 64'd0, 5'd1);
        wait_resp_a(lat);
        n_vec++; if (a_resp_data !== 64'hFFFFFFFFDEADBEEF) begin n_err++; $display("FAIL lw_data: got %h exp ffffffffdeadbeef", a_resp_data); end
        issue_a(1'b0, 3'b110, 64'h14, 64'd0, 5'd2);
        wait_resp_a(lat);
        n_vec++; if (a_resp_data !== 64'h00000000DEADBEEF) begin n_err++; $display("FAIL lwu_data: got %h exp 00000000deadbeef", a_resp_data); end
        a_mem_rdata = 64'h0000000080010000;
        issue_a(1'b0, 3'b001, 64'h12, 64'd0, 5'd3);
        wait_resp_a(lat);
        n_vec++; if (a_resp_data !== 64'hFFFFFFFFFFFF8001) begin n_err++; $display("FAIL lh_data: got %h exp ffffffffffff8001", a_resp_data); end
        issue_a(1'b0, 3'b101, 64'h12, 64'd0, 5'd3);
        wait_resp_a(lat);
        n_vec++; if (a_resp_data !== 64'h8001) begin n_err++; $display("FAIL lhu_data: got %h exp 8001", a_resp_data); end
        a_mem_rdata = 64'h0123456789ABCDEF;
        issue_a(1'b0, 3'b011, 64'h8, 64'd0, 5'd31);
        n_vec++; if (a_mem_addr !== 10'd1) begin n_err++; $display("FAIL ld_addr: got %h exp 1", a_mem_addr); end
        wait_resp_a(lat);
        n_vec++; if (lat !== 3 || a_resp_data !== 64'h0123456789ABCDEF || a_resp_rd !== 5'd31) begin
            n_err++; $display("FAIL ld_resp: got lat=%0d data=%h rd=%0d exp 3/0123456789abcdef/31", lat, a_resp_data, a_resp_rd); end
    endtask

    task automatic test_fault();
        int lat;
        issue_a(1'b0, 3'b010, 64'h16, 64'd0, 5'd9);
        n_vec++; if (a_mem_re !== 1'b0 || a_mem_we !== 8'h00) begin n_err++; $display("FAIL lwmis_mem: got re=%b we=%h exp 0/00", a_mem_re, a_mem_we); end
        wait_resp_a(lat);
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL lwmis_latency: got %0d exp 1", lat); end
        n_vec++; if (a_resp_fault !== 1'b1 || a_resp_data !== 64'd0 || a_resp_rd !== 5'd9) begin
            n_err++; $display("FAIL lwmis_resp: got fault=%b data=%h rd=%0d exp 1/0/9", a_resp_fault, a_resp_data, a_resp_rd); end
        issue_a(1'b0, 3'b111, 64'h0, 64'd0, 5'd4);
        wait_resp_a(lat);
        n_vec++; if (lat !== 1 || a_resp_fault !== 1'b1) begin n_err++; $display("FAIL ld111: got lat=%0d fault=%b exp 1/1", lat, a_resp_fault); end
        issue_a(1'b1, 3'b100, 64'h0, 64'hFF, 5'd0);
        n_vec++; if (a_mem_we !== 8'h00) begin n_err++; $display("FAIL st100_we: got %h exp 00", a_mem_we); end
        wait_resp_a(lat);
        n_vec++; if (lat !== 1 || a_resp_fault !== 1'b1) begin n_err++; $display("FAIL st100: got lat=%0d fault=%b exp 1/1", lat, a_resp_fault); end
        issue_a(1'b1, 3'b011, 64'h11, 64'h1, 5'd0);
        n_vec++; if (a_mem_we !== 8'h00) begin n_err++; $display("FAIL sdmis_we: got %h exp 00", a_mem_we); end
        wait_resp_a(lat);
        n_vec++; if (lat !== 1 || a_resp_fault !== 1'b1) begin n_err++; $display("FAIL sdmis: got lat=%0d fault=%b exp 1/1", lat, a_resp_fault); end
        // A good store after a fault clears the fault flag
        issue_a(1'b1, 3'b010, 64'h2010, 64'h12345678, 5'd6);
        n_vec++; if (a_mem_addr !== 10'd2 || a_mem_we !== 8'h0F) begin n_err++; $display("FAIL wrap_addr: got addr=%h we=%h exp 2/0f", a_mem_addr, a_mem_we); end
        wait_resp_a(lat);
        n_vec++; if (lat !== 2 || a_resp_fault !== 1'b0) begin n_err++; $display("FAIL wrap_resp: got lat=%0d fault=%b exp 2/0", lat, a_resp_fault); end
    endtask

    task automatic test_latency3();
        int lat;
        b_mem_rdata = 64'hDEADBEEF00000000;
        issue_b(1'b0, 3'b110, 64'h14, 64'd0, 5'd4);
        wait_resp_b(lat);
        n_vec++; if (lat !== 5) begin n_err++; $display("FAIL l3_latency: got %0d exp 5", lat); end
        n_vec++; if (b_resp_data !== 64'h00000000DEADBEEF || b_resp_rd !== 5'd4) begin
            n_err++; $display("FAIL l3_resp: got data=%h rd=%0d exp deadbeef/4", b_resp_data, b_resp_rd); end
    endtask

    task automatic test_reset_in_wait();
        logic seen;
        issue_b(1'b0, 3'b011, 64'h8, 64'd0, 5'd3);
        @(posedge clk); #1;
        // New request held high while the load is in WAIT
        b_req_valid = 1'b1; b_req_is_store = 1'b1; b_req_funct3 = 3'b011;
        b_req_addr = 64'h18; b_req_wdata = 64'h55; b_req_rd = 5'd0;
        n_vec++; if (b_req_ready !== 1'b0) begin n_err++; $display("FAIL rw_ready_wait: got %b exp 0", b_req_ready); end
        @(posedge clk); #1;
        n_vec++; if (b_mem_we !== 8'h00 || b_req_ready !== 1'b0) begin n_err++; $display("FAIL rw_not_taken: got we=%h rdy=%b exp 00/0", b_mem_we, b_req_ready); end
        @(negedge clk);
        b_rst_n = 1'b0;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        n_vec++; if (b_req_ready !== 1'b1 || b_resp_valid !== 1'b0) begin n_err++; $display("FAIL rw_idle: got rdy=%b valid=%b exp 1/0", b_req_ready, b_resp_valid); end
        n_vec++; if (b_resp_data !== 64'd0 || b_resp_rd !== 5'd0 || b_mem_addr !== 10'd0 || b_mem_re !== 1'b0) begin
            n_err++; $display("FAIL rw_cleared: got data=%h rd=%0d addr=%h re=%b exp 0/0/0/0", b_resp_data, b_resp_rd, b_mem_addr, b_mem_re); end
        @(negedge clk);
        b_rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (b_resp_valid || !b_req_ready) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rw_dropped: got stray activity=%b exp 0", seen); end
    endtask

    task automatic test_back_to_back();
        int lat, wek, st_lat;
        logic [63:0] got_data, we_data;
        logic [4:0]  got_rd;
        logic [9:0]  we_addr;
        lat = -1; wek = -1; st_lat = -1;
        got_data = '0; we_data = '0; got_rd = '0; we_addr = '0;
        b_mem_rdata = 64'h0123456789ABCDEF;
        issue_b(1'b0, 3'b011, 64'h8, 64'd0, 5'd3);
        b_req_valid = 1'b1; b_req_is_store = 1'b1; b_req_funct3 = 3'b011;
        b_req_addr = 64'h18; b_req_wdata = 64'h55; b_req_rd = 5'd0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (b_resp_valid && lat < 0) begin
                lat = k; got_data = b_resp_data; got_rd = b_resp_rd;
            end else if (b_resp_valid && st_lat < 0 && wek > 0) begin
                st_lat = k;
            end
            if (b_mem_we != 8'h00 && wek < 0) begin
                wek = k; we_addr = b_mem_addr; we_data = b_mem_wdata; b_req_valid = 1'b0;
            end
        end
        b_req_valid = 1'b0;
        n_vec++; if (lat !== 5) begin n_err++; $display("FAIL b2b_load_lat: got %0d exp 5", lat); end
        n_vec++; if (got_data !== 64'h0123456789ABCDEF || got_rd !== 5'd3) begin
            n_err++; $display("FAIL b2b_load_resp: got data=%h rd=%0d exp 0123456789abcdef/3", got_data, got_rd); end
        n_vec++; if (wek !== 7) begin n_err++; $display("FAIL b2b_store_access: got %0d exp 7", wek); end
        n_vec++; if (we_addr !== 10'd3 || we_data !== 64'h55) begin n_err++; $display("FAIL b2b_store_mem: got addr=%h wd=%h exp 3/55", we_addr, we_data); end
        n_vec++; if (st_lat !== 8) begin n_err++; $display("FAIL b2b_store_resp: got %0d exp 8", st_lat); end
    endtask

    initial begin
        a_rst_n = 1'b0; a_req_valid = 1'b0; a_req_is_store = 1'b0; a_req_funct3 = '0;
        a_req_addr = '0; a_req_wdata = '0; a_req_rd = '0; a_mem_rdata = '0;
        b_rst_n = 1'b0; b_req_valid = 1'b0; b_req_is_store = 1'b0; b_req_funct3 = '0;
        b_req_addr = '0; b_req_wdata = '0; b_req_rd = '0; b_mem_rdata = '0;
        test_reset();
        test_store_sd();
        test_store_sb();
        test_load_byte();
        test_load_half_word_double();
        test_fault();
        test_latency3();
        test_reset_in_wait();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
